ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the sending side for the existing keyboard receiver path. It sends a one-byte command such as 0xED (set LEDs) or 0xF4 (enable) to the keyboard. It drives the open-drain PS/2 clock and data lines through active-high pull-low enables, and follows the device-generated clock. It shares the ps2_clk/ps2_data pads with ps2_keyboard; top-level logic must hold the receiver's nextdata_n high while busy=1.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles allowed between consecutive device falling edges (15 ms at 50 MHz)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
tx_data  in  8  command byte
tx_valid  in  1  request; accepted when tx_valid && tx_ready
tx_ready  out  1  high only in IDLE
ps2_clk_in  in  1  sampled PS/2 clock pad
ps2_data_in  in  1  sampled PS/2 data pad
ps2_clk_oe  out  1  1 = pull ps2_clk low; 0 = release
ps2_data_oe  out  1  1 = pull ps2_data low; 0 = release
busy  out  1  high from acceptance until return to IDLE
done  out  1  one-cycle pulse: byte sent and device ACK seen
ack_err  out  1  one-cycle pulse: data not low at ACK edge
timeout_err  out  1  one-cycle pulse: device clock timeout

Behaviour:
- Interface: single clock clk; reset resetn is asynchronous and active-low.
- Reset (async, any state): state=IDLE; ps2_clk_oe=0, ps2_data_oe=0; tx_ready=1; busy=0; done, ack_err, timeout_err=0; counters=0. Reset mid-transfer releases both lines immediately.
- Input sync: ps2_clk_in passes through a 3-flop shift register. fall = s[2] & ~s[1], so an edge is seen 2-3 clk after the pad transition. ps2_data_in is 2-flop synced.
- Accept: tx_valid && tx_ready captures tx_data and parity = ~^tx_data (odd parity) into a 9-bit shift register {parity, data}. Next cycle the block enters INHIBIT with busy=1. tx_valid while busy is ignored and no queueing is done.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles. Then go to REQ.
- REQ: ps2_data_oe=1 (start bit 0) and ps2_clk_oe=1 for 1 cycle. Then ps2_clk_oe=0 and go to SEND with bit index 0. The timeout counter starts.
- SEND: on each fall, set ps2_data_oe = ~shift[0], shift right, idx++. Falls 1-8 place data bits LSB first; fall 9 places parity. On fall 10, set ps2_data_oe=0 (stop bit 1) and go to ACK.
- ACK: on the next fall (11th), sample the synced data. If 0, raise a done pulse; if 1, raise an ack_err pulse. Both cases go to WAIT_IDLE.
- WAIT_IDLE: stay until synced clk and data are both 1, then go to IDLE (tx_ready=1, busy=0). The same timeout applies here.
- Timeout: the counter resets on every fall in SEND/ACK/WAIT_IDLE. When it reaches TIMEOUT_CYCLES, the block releases both lines, pulses timeout_err for 1 cycle, and enters IDLE. done, ack_err and timeout_err are mutually exclusive per transfer.
- The block never drives ps2_clk except in INHIBIT/REQ, and never drives data high (open-drain only).
- Counters: inhibit/timeout counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1). Bit index is 4 bits.

Decomposition:
- Package ps2_pkg:
  - state enum {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE}
  - odd_parity function
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF
  - RX constant BREAK_CODE=8'hF0
- Sub-module ps2_sync_edge: 3-flop synchronizer plus falling-edge detector, reusable by ps2_keyboard.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz: ps2_clk_oe high for 5000 cycles. Data line after falls 1-10 reads 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACK low gives done=1 once and tx_ready back to 1.
- Send 0xF4: data bits 0,0,1,0,1,1,1,1, parity 0. Verify ps2_data_oe=1 from REQ until fall 1 (start bit).
- Device model omits ACK (data high at fall 11) -> ack_err pulse, no done, return to IDLE.
- Device never clocks after REQ -> timeout_err exactly TIMEOUT_CYCLES after clock release, both oe=0, tx_ready=1.
- Assert tx_valid with 0x55 during a 0xED transfer -> ignored: only 0xED appears on the line, and tx_ready stays 0 until done.
- Drop resetn low after fall 5 -> ps2_clk_oe and ps2_data_oe go 0 asynchronously. After release, a new 0xFF transfer completes with done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, parity helper and
// well-known keyboard command / scan-code bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] BREAK_CODE  = 8'hF0;

    // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and status between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_err, timeout_err
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_err, timeout_err
    );
endinterface

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for a PS/2 pad with a falling-edge strobe.
// The level output is the two-flop synchronized value.
module ps2_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic [2:0] sync_q;

    // Idle PS/2 lines float high, so the chain resets to ones to avoid a false edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], pad};
        end
    end

    assign level = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send,
// then shifts one command byte out on the device-generated clock.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clk,
    input  logic          resetn,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_HIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       idx_q, idx_d;
    logic             data_oe_q, data_oe_d;
    logic [8:0]       shift_q;
    logic             load_shift, step_shift;

    logic             clk_s, clk_fall;
    logic [1:0]       data_sync_q;
    logic             data_s;

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .resetn (resetn),
        .pad    (ps2_clk_in),
        .level  (clk_s),
        .fall   (clk_fall)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sync_q <= 2'b11;
        end else begin
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_oe_q <= data_oe_d;
        end
    end

    // Frame shifter: {parity, data}, consumed LSB first.
    always_ff @(posedge clk) begin
        if (load_shift) begin
            shift_q <= {odd_parity(tx.tx_data), tx.tx_data};
        end else if (step_shift) begin
            shift_q <= {1'b0, shift_q[8:1]};
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        data_oe_d      = data_oe_q;
        load_shift     = 1'b0;
        step_shift     = 1'b0;
        ps2_clk_oe     = 1'b0;
        tx.tx_ready    = 1'b0;
        tx.done        = 1'b0;
        tx.ack_err     = 1'b0;
        tx.timeout_err = 1'b0;

        case (state_q)
            IDLE: begin
                tx.tx_ready = 1'b1;
                cnt_d       = '0;
                idx_d       = '0;
                data_oe_d   = 1'b0;
                if (tx.tx_valid) begin
                    load_shift = 1'b1;
                    state_d    = INHIBIT;
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            REQ: begin
                ps2_clk_oe = 1'b1;
                cnt_d      = '0;
                idx_d      = '0;
                state_d    = SEND;
            end
            SEND: begin
                if (clk_fall) begin
                    cnt_d = '0;
                    if (idx_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end else begin
                        data_oe_d  = ~shift_q[0];
                        step_shift = 1'b1;
                        idx_d      = idx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d      = '0;
                    tx.done    = ~data_s;
                    tx.ack_err = data_s;
                    state_d    = WAIT_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // In WAIT_IDLE the outcome is already reported, so a stuck bus only returns us to IDLE.
        if ((state_q == SEND || state_q == ACK || state_q == WAIT_IDLE) &&
            !clk_fall && cnt_q == TMO_HIT) begin
            state_d        = IDLE;
            cnt_d          = '0;
            data_oe_d      = 1'b0;
            tx.timeout_err = (state_q != WAIT_IDLE);
        end
    end

    assign ps2_data_oe = data_oe_q & ~tx.timeout_err;
    assign tx.busy     = (state_q != IDLE);

endmodule
